regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the processor's 2-read/1-write register file.
- Adds N read ports and write-to-read bypass: a same-cycle write is returned on the read port instead of high-Z.
- Adds a per-register scoreboard of pending writes, used by the decode stage for hazard stalls.
- Sits between decode (reads, issue) and writeback (write port); register 0 is optionally hardwired to zero.

Parameters:
DATA_W, 32, data width of each register
NUM_REGS, 32, register count; power of two, >= 2
NUM_RD, 2, number of read ports, 1..4
BYPASS, 1, 1 = forward same-cycle write data to matching read ports; 0 = return stored value
ZERO_R0, 1, 1 = register 0 reads 0, ignores writes, never busy
(derived) AW = $clog2(NUM_REGS)

Ports:
clock  in  1  system clock, rising edge
ctrl_reset  in  1  asynchronous, active-high reset
ctrl_writeEnable  in  1  writeback write strobe
ctrl_writeReg  in  AW  write destination index
data_writeReg  in  DATA_W  write data
ctrl_readReg  in  NUM_RD*AW  packed read indices; port k = bits [k*AW +: AW]
data_readReg  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
data_readBusy  out  NUM_RD  port k's register has a pending write (effective busy, see below)
ctrl_issue  in  1  decode issued an instruction with a destination
ctrl_issueReg  in  AW  destination index of issued instruction
ctrl_flush  in  1  squash all pending writes (clear scoreboard)

Behaviour:
- Reset (async, ctrl_reset=1): all registers = 0; all busy bits = 0.
  - Outputs therefore read 0 and not-busy while reset is held.
  - Reset mid-operation discards any in-flight write or issue in that cycle.
- Read path is combinational, 0-cycle latency.
  - data_readReg[k] = regs[ctrl_readReg[k]].
  - Exception 1: ZERO_R0=1 and index = 0 -> read returns 0.
  - Exception 2: BYPASS=1, ctrl_writeEnable=1, ctrl_writeReg = ctrl_readReg[k], and the write is effective -> read returns data_writeReg.
  - Never drives Z.
- Write: on posedge clock, if ctrl_writeEnable and not (ZERO_R0 and ctrl_writeReg = 0) -> regs[ctrl_writeReg] <= data_writeReg.
- Scoreboard: busy[NUM_REGS] flops, updated on posedge clock in this priority:
  1. ctrl_flush = 1: all busy <= 0. Any issue in the same cycle is ignored.
  2. Otherwise, an effective write clears busy[ctrl_writeReg].
  3. Otherwise, ctrl_issue sets busy[ctrl_issueReg].
  - Issue and write to the same register in the same cycle: busy ends 1, because the new writer is pending.
  - ZERO_R0=1: busy[0] is never set.
- data_readBusy[k] = busy[idx] AND NOT (ctrl_writeEnable AND ctrl_writeReg = idx AND write effective).
  - Combinational; the write being committed this cycle resolves the hazard.
  - data_readBusy[k] is 0 for index 0 when ZERO_R0=1.
  - Issue has no same-cycle effect on data_readBusy.
- Multiple read ports may address the same register; every one of them gets the identical value and busy bit.
- A write to a register whose busy bit is 0 is legal: data is stored and busy stays 0.

Decomposition:
- Shared package proc_pkg holds:
  - REG_ZERO = 0;
  - default DATA_W / NUM_REGS constants;
  - function clog2 if the tool flow lacks $clog2.
- One sub-module, regfile_sb_rdport: one read mux plus bypass plus busy qualification, instantiated NUM_RD times in a generate loop.
- Storage and the scoreboard stay in the top module.

Test Plan:
1. Reset then read all 32 registers on both ports -> every data = 0x00000000 and busy = 0. Assert ctrl_reset asynchronously mid-cycle after writing R5=0x1234 -> R5 reads 0 immediately.
2. Bypass: write R7=0xDEADBEEF with readReg0=7 in the same cycle.
   - BYPASS=1 -> port0 = 0xDEADBEEF that cycle.
   - BYPASS=0 -> port0 = old value 0; next cycle both settings read 0xDEADBEEF.
3. R0 protection: write R0=0xFFFFFFFF and issue R0 -> R0 reads 0, busy0 = 0, including the bypass cycle.
4. Scoreboard: issue R3 -> next cycle busy(R3) = 1. Writeback R3=0x55 with readReg1=3 -> same cycle busy = 0 and data = 0x55; next cycle busy = 0.
5. Simultaneous events:
   - Issue R9 and write R9 in the same cycle -> busy(R9) = 1 afterwards.
   - Issue R4 and flush in the same cycle -> all busy = 0, including R4.
6. Parameter sweep NUM_REGS=16, DATA_W=64, NUM_RD=4: four ports read R15, R15, R1, R0 after writing R15=0x0123456789ABCDEF and R1=1 -> correct per-port values and packing.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor constants used by the register file and its read ports.
package proc_pkg;

    localparam int REG_ZERO         = 0;
    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;

    // Fallback for flows without $clog2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One register-file read port: storage mux, optional write bypass, busy qualification.
module regfile_sb_rdport
    import proc_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]              readIdx,
    input  logic [NUM_REGS*DATA_W-1:0] regFlat,
    input  logic [NUM_REGS-1:0]        busyVec,
    input  logic                       writeEffective,
    input  logic [AW-1:0]              writeIdx,
    input  logic [DATA_W-1:0]          writeData,
    output logic [DATA_W-1:0]          readData,
    output logic                       readBusy
);

    logic isZeroReg;
    logic hitsWrite;

    assign isZeroReg = (ZERO_R0 != 0) && (readIdx == AW'(REG_ZERO));
    assign hitsWrite = writeEffective && (writeIdx == readIdx);

    // A write committing this cycle resolves the hazard on its register.
    always_comb begin
        readData = regFlat[int'(readIdx)*DATA_W +: DATA_W];
        readBusy = busyVec[readIdx] && !hitsWrite;
        if (isZeroReg) begin
            readData = '0;
            readBusy = 1'b0;
        end else if ((BYPASS != 0) && hitsWrite) begin
            readData = writeData;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and a pending-write scoreboard.
module regfile_sb
    import proc_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     ctrl_writeEnable,
    input  logic [AW-1:0]            ctrl_writeReg,
    input  logic [DATA_W-1:0]        data_writeReg,
    input  logic [NUM_RD*AW-1:0]     ctrl_readReg,
    output logic [NUM_RD*DATA_W-1:0] data_readReg,
    output logic [NUM_RD-1:0]        data_readBusy,
    input  logic                     ctrl_issue,
    input  logic [AW-1:0]            ctrl_issueReg,
    input  logic                     ctrl_flush
);

    logic [DATA_W-1:0]          regs [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regFlat;
    logic [NUM_REGS-1:0]        busy;
    logic [NUM_REGS-1:0]        busyNext;
    logic                       writeEffective;
    logic                       issueEffective;

    // Gating with reset keeps the bypass path from leaking data while reset is held.
    assign writeEffective = ctrl_writeEnable && !ctrl_reset &&
                            !((ZERO_R0 != 0) && (ctrl_writeReg == AW'(REG_ZERO)));
    assign issueEffective = ctrl_issue &&
                            !((ZERO_R0 != 0) && (ctrl_issueReg == AW'(REG_ZERO)));

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEffective) begin
            regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Issue is applied after the write clear so a same-register pair stays pending.
    always_comb begin
        busyNext = busy;
        if (ctrl_flush) begin
            busyNext = '0;
        end else begin
            if (writeEffective) begin
                busyNext[ctrl_writeReg] = 1'b0;
            end
            if (issueEffective) begin
                busyNext[ctrl_issueReg] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : gFlatten
        assign regFlat[g*DATA_W +: DATA_W] = regs[g];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gReadPort
        regfile_sb_rdport #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .BYPASS  (BYPASS),
            .ZERO_R0 (ZERO_R0)
        ) uReadPort (
            .readIdx       (ctrl_readReg[k*AW +: AW]),
            .regFlat       (regFlat),
            .busyVec       (busy),
            .writeEffective(writeEffective),
            .writeIdx      (ctrl_writeReg),
            .writeData     (data_writeReg),
            .readData      (data_readReg[k*DATA_W +: DATA_W]),
            .readBusy      (data_readBusy[k])
        );
    end

endmodule
